// File: rtl/word_serializer_hs.sv
// Word-to-bit serializer for the modem transmit path: per-word bit order, optional
// DPSK encoding, valid/ready on both sides and a one-deep pending slot for gapless streaming.
//
// state  | meaning
// S_IDLE | active slot empty, bit outputs driven 0
// S_BUSY | active slot holds a word, bit_out presents its current bit
module word_serializer_hs #(
    parameter int   WIDTH     = 12,
    parameter int   CNT_W     = 6,
    parameter logic DIFF_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             lsb_first,
    input  logic             diff_en,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_first,
    output logic             bit_last,
    output logic             busy
);
    typedef enum logic {S_IDLE, S_BUSY} act_state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    act_state_t       state, state_n;
    logic [WIDTH-1:0] act_shift, act_shift_n;
    logic [CNT_W-1:0] act_idx, act_idx_n;
    logic             act_diff, act_diff_n;
    logic             pend_full, pend_full_n;
    logic [WIDTH-1:0] pend_word, pend_word_n;
    logic             pend_lsb, pend_lsb_n;
    logic             pend_diff, pend_diff_n;
    logic             hist, hist_n;
    logic             rdy_q;
    logic             out_bit, out_bit_n;
    logic             out_first, out_first_n;
    logic             out_last, out_last_n;

    logic             xfer, last_xfer, accept, act_free;
    logic             ld;
    logic [WIDTH-1:0] ld_word, ld_ord;
    logic             ld_lsb, ld_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            act_shift <= '0;
            act_idx   <= '0;
            act_diff  <= 1'b0;
            pend_full <= 1'b0;
            pend_word <= '0;
            pend_lsb  <= 1'b0;
            pend_diff <= 1'b0;
            hist      <= DIFF_INIT;
            rdy_q     <= 1'b0;
            out_bit   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            act_shift <= act_shift_n;
            act_idx   <= act_idx_n;
            act_diff  <= act_diff_n;
            pend_full <= pend_full_n;
            pend_word <= pend_word_n;
            pend_lsb  <= pend_lsb_n;
            pend_diff <= pend_diff_n;
            hist      <= hist_n;
            rdy_q     <= ~pend_full_n;
            out_bit   <= out_bit_n;
            out_first <= out_first_n;
            out_last  <= out_last_n;
        end
    end

    always_comb begin
        state_n     = state;
        act_shift_n = act_shift;
        act_idx_n   = act_idx;
        act_diff_n  = act_diff;
        pend_full_n = pend_full;
        pend_word_n = pend_word;
        pend_lsb_n  = pend_lsb;
        pend_diff_n = pend_diff;
        out_bit_n   = out_bit;
        out_first_n = out_first;
        out_last_n  = out_last;
        ld          = 1'b0;
        ld_word     = word_in;
        ld_lsb      = lsb_first;
        ld_diff     = diff_en;
        ld_ord      = '0;

        xfer      = (state == S_BUSY) && bit_ready;
        last_xfer = xfer && (act_idx == LAST_IDX);
        accept    = word_valid && rdy_q;
        act_free  = (state == S_IDLE) || last_xfer;
        // history follows whatever bit actually left, encoded or not
        hist_n    = xfer ? out_bit : hist;

        if (act_free) begin
            if (pend_full) begin
                ld          = 1'b1;
                ld_word     = pend_word;
                ld_lsb      = pend_lsb;
                ld_diff     = pend_diff;
                pend_full_n = 1'b0;
            end else if (accept) begin
                ld = 1'b1;
            end else begin
                state_n     = S_IDLE;
                out_bit_n   = 1'b0;
                out_first_n = 1'b0;
                out_last_n  = 1'b0;
            end
        end else begin
            if (accept) begin
                pend_full_n = 1'b1;
                pend_word_n = word_in;
                pend_lsb_n  = lsb_first;
                pend_diff_n = diff_en;
            end
            if (xfer) begin
                act_shift_n = act_shift << 1;
                act_idx_n   = act_idx + CNT_W'(1);
                out_first_n = 1'b0;
                out_last_n  = (act_idx_n == LAST_IDX);
                out_bit_n   = act_shift_n[WIDTH-1] ^ (act_diff & hist_n);
            end
        end

        // words are stored in emission order so the shifter always leaves from the top
        if (ld) begin
            for (int i = 0; i < WIDTH; i++)
                ld_ord[i] = ld_lsb ? ld_word[WIDTH-1-i] : ld_word[i];
            state_n     = S_BUSY;
            act_shift_n = ld_ord;
            act_idx_n   = '0;
            act_diff_n  = ld_diff;
            out_first_n = 1'b1;
            out_last_n  = (WIDTH == 1);
            out_bit_n   = ld_ord[WIDTH-1] ^ (ld_diff & hist_n);
        end
    end

    assign bit_valid  = (state == S_BUSY);
    assign bit_out    = out_bit;
    assign bit_first  = out_first;
    assign bit_last   = out_last;
    assign word_ready = rdy_q;
    assign busy       = (state == S_BUSY) || pend_full;

endmodule
